mem_max_scanner: RTL and testbench

Sequential scan engine that sits directly upstream of the 8-bit data memory. On a start request it drives the memory address port over a contiguous window of words, consumes the combinational read data, and tracks the unsigned maximum and its offset. It optionally writes both results back into the memory through the same write port. It is the hardware counterpart of the array-maximum routine run over the preloaded table at addresses 100–121.

---
 rtl/mem_max_scanner_pkg.sv | 19 +
 rtl/mem_max_scanner_tracker.sv | 32 +++
 rtl/mem_max_scanner.sv | 113 +++++++++++
 tb/tb_mem_max_scanner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_max_scanner_pkg.sv
// Purpose : shared widths and scanner state encoding for the memory max-scan engine.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: ADDR_W / DATA_W defaults (must match the 8-bit data memory), state_t encoding.
package mem_max_scanner_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  // 3-bit state encoding, IDLE=0 so a cleared register lands in IDLE.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    WR_VAL = 3'd2,
    WR_IDX = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mem_max_scanner_tracker.sv
// Purpose : registered running maximum (unsigned) and the offset of its first occurrence.
// Latency : result visible the cycle after the sample that produced it.
// Backpr. : none; a sample is taken on every cycle 'sample' is high.
// Ports   : clock, reset (sync, active-high), clear, sample, first, data, index -> maxValue, maxIndex.
module max_tracker #(
  parameter int ADDR_W = mem_max_scanner_pkg::ADDR_W,
  parameter int DATA_W = mem_max_scanner_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              sample,
  input  logic              first,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] index,
  output logic [DATA_W-1:0] maxValue,
  output logic [ADDR_W-1:0] maxIndex
);

  // Strict compare: an equal later word never displaces the earlier index.
  // 'first' forces a load so the first word seeds the maximum regardless of value.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      maxValue <= '0;
      maxIndex <= '0;
    end else if (sample && (first || (data > maxValue))) begin
      maxValue <= data;
      maxIndex <= index;
    end
  end

endmodule

// File: rtl/mem_max_scanner.sv
// Purpose : scans a contiguous (mod-256) memory window for the unsigned max and optionally writes it back.
// Latency : start edge to done cycle = count + 2*wbEnable + 1 cycles (1 cycle when count=0).
// Backpr. : none; start is only sampled in IDLE, starts while busy are dropped (no queueing).
// Ports   : clock, reset, start, base, count, wbEnable, resultAddr, memOut -> memAddress, memWrite,
//           memData, busy, done, maxValue, maxIndex.
module mem_max_scanner #(
  parameter int ADDR_W = mem_max_scanner_pkg::ADDR_W,
  parameter int DATA_W = mem_max_scanner_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  input  logic              wbEnable,
  input  logic [ADDR_W-1:0] resultAddr,
  output logic [ADDR_W-1:0] memAddress,
  output logic              memWrite,
  output logic [DATA_W-1:0] memData,
  input  logic [DATA_W-1:0] memOut,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] maxValue,
  output logic [ADDR_W-1:0] maxIndex
);

  import mem_max_scanner_pkg::*;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q, count_q, result_q, off_q;
  logic              wb_q;
  logic              accept;
  logic              last;

  assign accept = (state == IDLE) && start;
  assign last   = (off_q == (count_q - ADDR_W'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      base_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      wb_q     <= 1'b0;
      off_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        base_q   <= base;
        count_q  <= count;
        result_q <= resultAddr;
        wb_q     <= wbEnable;
        off_q    <= '0;
      end else if ((state == SCAN) && !last) begin
        off_q <= off_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nx   = state;
    memAddress = '0;
    memWrite   = 1'b0;
    memData    = '0;
    case (state)
      IDLE: begin
        // count=0 skips the scan and the write-back entirely.
        if (start) state_nx = (count == '0) ? DONE : SCAN;
      end
      SCAN: begin
        memAddress = base_q + off_q;  // wraps naturally at ADDR_W bits
        if (last) state_nx = wb_q ? WR_VAL : DONE;
      end
      WR_VAL: begin
        memAddress = result_q;
        memWrite   = 1'b1;
        memData    = maxValue;
        state_nx   = WR_IDX;
      end
      WR_IDX: begin
        memAddress = result_q + ADDR_W'(1);
        memWrite   = 1'b1;
        memData    = DATA_W'(maxIndex);
        state_nx   = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  max_tracker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_tracker (
    .clock    (clock),
    .reset    (reset),
    .clear    (accept),
    .sample   (state == SCAN),
    .first    (off_q == '0),
    .data     (memOut),
    .index    (off_q),
    .maxValue (maxValue),
    .maxIndex (maxIndex)
  );

endmodule

// File: tb/tb_mem_max_scanner.sv
// Purpose : self-checking bench for mem_max_scanner with a behavioural data memory and reference model.
// Latency : n/a.
// Backpr. : n/a.
module tb_mem_max_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base = '0, count = '0, resultAddr = '0;
  logic       wbEnable = 1'b0;
  logic [7:0] memAddress, memData, memOut, maxValue, maxIndex;
  logic       memWrite, busy, done;

  int total = 0;
  int bad   = 0;

  // Behavioural data memory: combinational read, posedge write. The bench has its own write port.
  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_wa = '0, tb_wd = '0;

  assign memOut = mem[memAddress];

  always @(posedge clock) begin
    if (memWrite) mem[memAddress] <= memData;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  always #5 clock = ~clock;

  mem_max_scanner dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .count      (count),
    .wbEnable   (wbEnable),
    .resultAddr (resultAddr),
    .memAddress (memAddress),
    .memWrite   (memWrite),
    .memData    (memData),
    .memOut     (memOut),
    .busy       (busy),
    .done       (done),
    .maxValue   (maxValue),
    .maxIndex   (maxIndex)
  );

  logic [7:0] tbl [22] = '{8'd12, 8'd45, 8'd7, 8'd99, 8'd33, 8'd118, 8'd64, 8'd2, 8'd87, 8'd101, 8'd56,
                           8'd119, 8'd3, 8'd77, 8'd90, 8'd115, 8'd8, 8'd120, 8'd44, 8'd120, 8'd19, 8'd110};

  // Observations collected by run_scan.
  logic [7:0] reads[$];
  logic [7:0] waddr[$];
  logic [7:0] wdata[$];
  int lat, md_bad, busy_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tb_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  // Reference: find the largest word in the window, then the first offset holding it.
  task automatic model(input logic [7:0] b, input logic [7:0] c, output logic [7:0] mx, output logic [7:0] ix);
    int vals[$];
    mx = 0; ix = 0;
    for (int j = 0; j < int'(c); j++) vals.push_back(int'(mem[8'(int'(b) + j)]));
    foreach (vals[j]) if (vals[j] > int'(mx)) mx = 8'(vals[j]);
    for (int j = vals.size() - 1; j >= 0; j--) if (vals[j] == int'(mx)) ix = 8'(j);
  endtask

  task automatic run_scan(input logic [7:0] b, input logic [7:0] c, input logic wb, input logic [7:0] ra,
                          input bit noise);
    reads.delete(); waddr.delete(); wdata.delete();
    lat = -1; md_bad = 0; busy_bad = 0;
    @(negedge clock);
    base = b; count = c; wbEnable = wb; resultAddr = ra; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clock);
      if (noise) begin
        // Inputs are latched at start; anything driven now must be ignored.
        start = 1'($urandom); base = 8'($urandom); count = 8'($urandom);
        wbEnable = 1'($urandom); resultAddr = 8'($urandom);
      end
      if (!busy) busy_bad++;
      if (memWrite) begin
        waddr.push_back(memAddress);
        wdata.push_back(memData);
      end else begin
        if (memData !== 8'd0) md_bad++;
        if (busy && !done) reads.push_back(memAddress);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic scan_and_check(input string nm, input logic [7:0] b, input logic [7:0] c, input logic wb,
                                input logic [7:0] ra, input bit noise);
    logic [7:0] emx, eix;
    int aerr;
    int nw;
    model(b, c, emx, eix);
    run_scan(b, c, wb, ra, noise);
    nw = (wb && c != 0) ? 2 : 0;
    chk({nm, " latency"}, lat, int'(c) + nw + 1);
    chk({nm, " maxValue"}, maxValue, emx);
    chk({nm, " maxIndex"}, maxIndex, eix);
    chk({nm, " busy_gaps"}, busy_bad, 0);
    chk({nm, " memData_idle"}, md_bad, 0);
    chk({nm, " write_count"}, waddr.size(), nw);
    aerr = (reads.size() == int'(c)) ? 0 : 1000;
    foreach (reads[j]) if (reads[j] !== 8'(int'(b) + j)) aerr++;
    chk({nm, " read_addrs"}, aerr, 0);
    if (nw == 2 && waddr.size() == 2) begin
      chk({nm, " wr0_addr"}, waddr[0], ra);
      chk({nm, " wr0_data"}, wdata[0], emx);
      chk({nm, " wr1_addr"}, waddr[1], 8'(ra + 8'd1));
      chk({nm, " wr1_data"}, wdata[1], eix);
      chk({nm, " mem_val"}, mem[ra], emx);
      chk({nm, " mem_idx"}, mem[8'(ra + 8'd1)], eix);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dseen;
    int bseen;
    // Preload memory while reset is held.
    for (int a = 0; a < 256; a++) begin
      @(negedge clock);
      tb_we = 1'b1; tb_wa = 8'(a);
      tb_wd = (a >= 100 && a <= 121) ? tbl[a - 100] : 8'($urandom_range(0, 255));
    end
    @(negedge clock);
    tb_we = 1'b0;

    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst memWrite", memWrite, 1'b0);
    chk("rst memAddress", memAddress, 8'd0);
    chk("rst memData", memData, 8'd0);
    chk("rst maxValue", maxValue, 8'd0);
    chk("rst maxIndex", maxIndex, 8'd0);
    reset = 1'b0;

    // Table scan, no write-back.
    scan_and_check("tbl", 8'd100, 8'd22, 1'b0, 8'd130, 1'b0);
    chk("tbl max_const", maxValue, 8'd120);
    chk("tbl idx_const", maxIndex, 8'd17);
    chk("tbl lat_const", lat, 23);
    repeat (3) @(negedge clock);
    chk("tbl hold_val", maxValue, 8'd120);
    chk("tbl hold_idx", maxIndex, 8'd17);

    // Table scan with write-back.
    scan_and_check("tbl_wb", 8'd100, 8'd22, 1'b1, 8'd130, 1'b0);
    chk("tbl_wb mem130", mem[130], 8'd120);
    chk("tbl_wb mem131", mem[131], 8'd17);
    chk("tbl_wb lat_const", lat, 25);

    // Tie keeps the first index.
    tb_write(8'd200, 8'd5); tb_write(8'd201, 8'd9); tb_write(8'd202, 8'd9);
    scan_and_check("tie", 8'd200, 8'd3, 1'b0, 8'd0, 1'b0);
    chk("tie idx_const", maxIndex, 8'd1);

    // Window wraps 255 -> 0.
    tb_write(8'd254, 8'd1); tb_write(8'd255, 8'd2); tb_write(8'd0, 8'd200); tb_write(8'd1, 8'd3);
    scan_and_check("wrap", 8'd254, 8'd4, 1'b0, 8'd0, 1'b0);
    chk("wrap max_const", maxValue, 8'd200);
    chk("wrap idx_const", maxIndex, 8'd2);

    // Empty window with write-back requested.
    scan_and_check("cnt0", 8'd100, 8'd0, 1'b1, 8'd50, 1'b0);
    chk("cnt0 lat_const", lat, 1);
    chk("cnt0 max_const", maxValue, 8'd0);

    // Reset (with a start) on the 5th scan cycle.
    @(negedge clock);
    base = 8'd100; count = 8'd22; wbEnable = 1'b0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    chk("rstmid busy", busy, 1'b0);
    chk("rstmid done", done, 1'b0);
    chk("rstmid memWrite", memWrite, 1'b0);
    chk("rstmid maxValue", maxValue, 8'd0);
    chk("rstmid maxIndex", maxIndex, 8'd0);
    reset = 1'b0; start = 1'b0;
    dseen = 0; bseen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done) dseen++;
      if (busy) bseen++;
    end
    chk("rstmid no_done", dseen, 0);
    chk("rstmid stays_idle", bseen, 0);
    scan_and_check("after_rst", 8'd100, 8'd22, 1'b0, 8'd0, 1'b0);
    chk("after_rst max_const", maxValue, 8'd120);
    chk("after_rst idx_const", maxIndex, 8'd17);

    // Randomized scans with disturbance on inputs while busy.
    for (int t = 0; t < 20; t++) begin
      for (int w = 0; w < 4; w++) tb_write(8'($urandom), 8'($urandom));
      scan_and_check($sformatf("rnd%0d", t), 8'($urandom), 8'($urandom_range(0, 60)), 1'($urandom),
                     8'($urandom), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
